dff_pipeline: RTL and testbench

- Parametrised successor to the single-bit D flip-flop: a DEPTH-stage, WIDTH-bit registered delay line with a valid/ready handshake on both ends.
- Each stage is a D register plus a valid bit. Stages advance independently, so bubbles collapse and back-pressure stalls only the stages that are full.
- Used as the standard retiming/delay element between lab datapath blocks. Full throughput is one word per clock.

---
 rtl/dff_pipeline_pkg.sv | 17 +
 rtl/dff_pipeline_if.sv | 27 ++
 rtl/dff_pipe_stage.sv | 36 +++
 rtl/dff_pipeline.sv | 89 ++++++++
 tb/tb_dff_pipeline.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/dff_pipeline_pkg.sv
// Shared constants, count-width helper and stage record for the dff_pipeline delay line.
package dff_pipeline_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 4;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Stage record at the default word width
    typedef struct packed {
        logic                 valid;
        logic [DEF_WIDTH-1:0] data;
    } stage_t;

endpackage

// File: rtl/dff_pipeline_if.sv
// Valid/ready bus of the dff_pipeline: upstream side, downstream side and occupancy count.
interface dff_pipeline_if
    import dff_pipeline_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
);

    logic                     in_valid;
    logic [WIDTH-1:0]         in_data;
    logic                     in_ready;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic                     out_ready;
    logic [cnt_w(DEPTH)-1:0]  count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: valid bit plus data register; data loads only when a valid word arrives.
module dff_pipe_stage #(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_mv,
    input  logic             i_prev_valid,
    input  logic [WIDTH-1:0] i_prev_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= RESET_DATA;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_mv) begin
            r_valid <= i_prev_valid;
            // A bubble moving in leaves the data register untouched
            if (i_prev_valid)
                r_data <= i_prev_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/dff_pipeline.sv
// DEPTH-stage, WIDTH-bit registered delay line with valid/ready handshake on both ends.
// Optional synchronous clear of all valid bits via port flush when DFF_PIPELINE_FLUSH_EN is defined.
module dff_pipeline
    import dff_pipeline_pkg::*;
#(
    parameter int unsigned      WIDTH      = DEF_WIDTH,
    parameter int unsigned      DEPTH      = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef DFF_PIPELINE_FLUSH_EN
    input  logic            flush,
`endif
    dff_pipeline_if.slave   bus
);

    localparam int unsigned CW = cnt_w(DEPTH);

    logic [DEPTH-1:0] w_v;
    logic [WIDTH-1:0] w_d [DEPTH];
    logic [DEPTH-1:0] w_mv;
    logic             w_flush;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [CW-1:0]    r_count;

`ifdef DFF_PIPELINE_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // mv[i] = !v[i] | mv[i+1] unrolled: a stage may move unless it and every stage ahead are full and stalled
    always_comb begin
        logic w_tail_full;
        w_mv        = '0;
        w_tail_full = 1'b1;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            w_tail_full             = w_tail_full & w_v[DEPTH-1-j];
            w_mv[DEPTH-1-j]         = !w_tail_full | bus.out_ready;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             w_pv;
        logic [WIDTH-1:0] w_pd;

        if (g == 0) begin : g_head
            assign w_pv = bus.in_valid;
            assign w_pd = bus.in_data;
        end else begin : g_body
            assign w_pv = w_v[g-1];
            assign w_pd = w_d[g-1];
        end

        dff_pipe_stage #(
            .WIDTH      (WIDTH),
            .RESET_DATA (RESET_DATA)
        ) u_stage (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_clr        (w_flush),
            .i_mv         (w_mv[g]),
            .i_prev_valid (w_pv),
            .i_prev_data  (w_pd),
            .o_valid      (w_v[g]),
            .o_data       (w_d[g])
        );
    end

    assign bus.in_ready  = w_mv[0] & rst_n & !w_flush;
    assign bus.out_valid = w_v[DEPTH-1];
    assign bus.out_data  = w_d[DEPTH-1];
    assign bus.count     = r_count;

    assign w_in_xfer  = bus.in_valid & bus.in_ready;
    assign w_out_xfer = bus.out_valid & bus.out_ready & !w_flush;

    always_ff @(posedge clk) begin
        if (!rst_n || w_flush)
            r_count <= '0;
        else if (w_in_xfer && !w_out_xfer)
            r_count <= r_count + 1'b1;
        else if (w_out_xfer && !w_in_xfer)
            r_count <= r_count - 1'b1;
    end

endmodule

// File: tb/tb_dff_pipeline.sv
// Directed bench for dff_pipeline (WIDTH=8, DEPTH=4); flush scenario included when DFF_PIPELINE_FLUSH_EN is defined.
module tb_dff_pipeline;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    dff_pipeline_if #(.WIDTH(8), .DEPTH(4)) bus ();

    dff_pipeline #(
        .WIDTH      (8),
        .DEPTH      (4),
        .RESET_DATA (8'h00)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef DFF_PIPELINE_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven and outputs sampled mid-cycle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] val);
        bus.in_valid = 1'b1;
        bus.in_data  = val;
        #1;
        chk("load_in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hAA;
        bus.out_ready = 1'b0;

        // Reset with in_valid asserted
        tick();
        tick();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 8'h00);
        chk("rst_count", bus.count, 0);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("rel_in_ready", bus.in_ready, 1);
        chk("rel_out_valid", bus.out_valid, 0);

        // Streaming 01..08 with out_ready=1
        bus.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            bus.in_valid = (c < 8);
            bus.in_data  = 8'(c + 1);
            #1;
            chk("str_out_valid", bus.out_valid, (c >= 4) ? 1 : 0);
            if (c >= 4)
                chk("str_out_data", bus.out_data, c - 3);
            chk("str_count", bus.count, (c <= 4) ? c : ((c <= 8) ? 4 : 12 - c));
            if (c < 8)
                chk("str_in_ready", bus.in_ready, 1);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("str_end_valid", bus.out_valid, 0);
        chk("str_end_count", bus.count, 0);

        // Back-pressure: fill 10..13 while stalled
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            load(8'(8'h10 + k));
        for (int k = 0; k < 2; k++) begin
            chk("bp_count", bus.count, 4);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_out_data", bus.out_data, 8'h10);
            tick();
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_drain_valid", bus.out_valid, 1);
            chk("bp_drain_data", bus.out_data, 8'h10 + k);
            tick();
        end
        chk("bp_empty_valid", bus.out_valid, 0);
        chk("bp_empty_count", bus.count, 0);

        // Bubble collapse against a stalled tail
        bus.out_ready = 1'b0;
        load(8'h21);
        tick();
        tick();
        load(8'h22);
        for (int k = 0; k < 3; k++)
            tick();
        chk("bub_count", bus.count, 2);
        chk("bub_out_valid", bus.out_valid, 1);
        chk("bub_out_data", bus.out_data, 8'h21);
        bus.out_ready = 1'b1;
        #1;
        tick();
        chk("bub_second_valid", bus.out_valid, 1);
        chk("bub_second_data", bus.out_data, 8'h22);
        tick();
        chk("bub_empty_valid", bus.out_valid, 0);
        chk("bub_empty_count", bus.count, 0);

        // Full pipeline: simultaneous accept and emit for 10 cycles
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            load(8'(8'h30 + k));
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h34 + k);
            #1;
            chk("full_in_ready", bus.in_ready, 1);
            chk("full_out_valid", bus.out_valid, 1);
            chk("full_out_data", bus.out_data, 8'h30 + k);
            chk("full_count", bus.count, 4);
            tick();
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("full_drain_data", bus.out_data, 8'h3A + k);
            chk("full_drain_count", bus.count, 4 - k);
            tick();
        end
        chk("full_empty_valid", bus.out_valid, 0);

        // Mid-operation reset with 3 words in flight
        bus.out_ready = 1'b0;
        load(8'h40);
        load(8'h41);
        load(8'h42);
        chk("mrst_pre_count", bus.count, 3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("mrst_count", bus.count, 0);
        chk("mrst_out_valid", bus.out_valid, 0);
        chk("mrst_out_data", bus.out_data, 8'h00);
        chk("mrst_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("mrst_no_residual", bus.out_valid, 0);
        end

`ifdef DFF_PIPELINE_FLUSH_EN
        // Flush with 3 words in flight; data registers keep their contents
        bus.out_ready = 1'b0;
        load(8'h50);
        load(8'h51);
        load(8'h52);
        tick();
        chk("fl_pre_valid", bus.out_valid, 1);
        chk("fl_pre_data", bus.out_data, 8'h50);
        chk("fl_pre_count", bus.count, 3);
        flush         = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h99;
        #1;
        chk("fl_in_ready", bus.in_ready, 0);
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("fl_count", bus.count, 0);
        chk("fl_out_valid", bus.out_valid, 0);
        chk("fl_out_data_kept", bus.out_data, 8'h50);
        chk("fl_in_ready_after", bus.in_ready, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("fl_no_residual", bus.out_valid, 0);
        end
        load(8'h60);
        tick();
        tick();
        chk("fl_recover_valid", bus.out_valid, 0);
        tick();
        chk("fl_recover_valid2", bus.out_valid, 1);
        chk("fl_recover_data", bus.out_data, 8'h60);
        tick();
        chk("fl_recover_empty", bus.out_valid, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
